// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU ops,
// mux selects, FSM states and the control word driven to the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b110;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11
  } stateT;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteBeq;
    logic       pcWriteBne;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrlWordT;

  function automatic logic isSupported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_LW, OP_SW,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: isSupported = 1'b1;
      default:                           isSupported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational control-word decoder: state (+opcode, +mem_ready for the
// FETCH Mealy terms) to datapath mux selects and enables.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter bit FETCH_ONLY_DEBUG = 1'b0
) (
  input  stateT      state,
  input  logic [5:0] opcode,
  input  logic       memReady,
  output ctrlWordT   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.irWrite = memReady;
        ctrl.pcWrite = memReady;
      end
      DECODE: begin
        ctrl.aluSrcB   = SRCB_IMM_SH;
        ctrl.illegalOp = (FETCH_ONLY_DEBUG == 1'b0) && !isSupported(opcode);
      end
      MEM_ADDR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iOrD    = 1'b1;
      end
      MEM_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
      end
      MEM_WR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iOrD     = 1'b1;
      end
      R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALU_RTYPE;
      end
      R_WB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_B;
        ctrl.aluOp      = ALU_SUB;
        ctrl.pcSource   = PCSRC_ALUOUT;
        ctrl.pcWriteBeq = (opcode == OP_BEQ);
        ctrl.pcWriteBne = (opcode == OP_BNE);
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
      I_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        case (opcode)
          OP_ANDI: ctrl.aluOp = ALU_AND;
          OP_ORI:  ctrl.aluOp = ALU_OR;
          OP_SLTI: ctrl.aluOp = ALU_SLT;
          default: ctrl.aluOp = ALU_ADD;
        endcase
      end
      I_WB: begin
        ctrl.regWrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register and next-state logic; the
// control word comes from multicycle_ctrl_outdec.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter bit FETCH_ONLY_DEBUG = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  stateT    curState;
  stateT    nextState;
  ctrlWordT ctrl;
  ctrlWordT ctrlOut;
  logic     unusedZero;

  // zero is resolved by the datapath PC-enable logic, not by the FSM
  assign unusedZero = zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) curState <= FETCH;
    else          curState <= nextState;
  end

  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:    nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (FETCH_ONLY_DEBUG) begin
          nextState = FETCH;
        end else begin
          case (opcode)
            OP_RTYPE:                         nextState = R_EXEC;
            OP_LW, OP_SW:                     nextState = MEM_ADDR;
            OP_BEQ, OP_BNE:                   nextState = BRANCH;
            OP_J:                             nextState = JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nextState = I_EXEC;
            default:                          nextState = FETCH;
          endcase
        end
      end
      MEM_ADDR: nextState = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   nextState = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   nextState = FETCH;
      MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
      R_EXEC:   nextState = R_WB;
      R_WB:     nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      I_EXEC:   nextState = I_WB;
      I_WB:     nextState = FETCH;
      default:  nextState = FETCH;
    endcase
  end

  multicycle_ctrl_outdec #(
    .FETCH_ONLY_DEBUG(FETCH_ONLY_DEBUG)
  ) uOutdec (
    .state   (curState),
    .opcode  (opcode),
    .memReady(mem_ready),
    .ctrl    (ctrl)
  );

  // Reset must force every output low, including FETCH's mem_read
  assign ctrlOut = reset_n ? ctrl : '0;

  assign pc_write     = ctrlOut.pcWrite;
  assign pc_write_beq = ctrlOut.pcWriteBeq;
  assign pc_write_bne = ctrlOut.pcWriteBne;
  assign i_or_d       = ctrlOut.iOrD;
  assign mem_read     = ctrlOut.memRead;
  assign mem_write    = ctrlOut.memWrite;
  assign ir_write     = ctrlOut.irWrite;
  assign reg_dst      = ctrlOut.regDst;
  assign mem_to_reg   = ctrlOut.memToReg;
  assign reg_write    = ctrlOut.regWrite;
  assign alu_src_a    = ctrlOut.aluSrcA;
  assign alu_src_b    = ctrlOut.aluSrcB;
  assign alu_op       = ctrlOut.aluOp;
  assign pc_source    = ctrlOut.pcSource;
  assign illegal_op   = ctrlOut.illegalOp;
  assign state        = curState;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// traces built from instruction class and stall counts, checked every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_controller #(.FETCH_ONLY_DEBUG(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_beq(pc_write_beq),
    .pc_write_bne(pc_write_bne), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] RTYPE = 6'b000000, JMP = 6'b000010, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, beq, bne, iord, mrd, mwr, irw, rdst, m2r, rw, srcA;
    logic [1:0] srcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic ill;
  } obsT;

  typedef struct { obsT exp; logic mr; } stepT;

  obsT  expQ[$];
  stepT trace[$];
  int   tests = 0, fails = 0;
  int   illCnt = 0, rwCnt = 0, mwCnt = 0;
  obsT  cmpExp, cmpAct, zeroObs, fetchIdle;

  function automatic obsT observed();
    obsT o;
    o.st = state; o.pcw = pc_write; o.beq = pc_write_beq; o.bne = pc_write_bne;
    o.iord = i_or_d; o.mrd = mem_read; o.mwr = mem_write; o.irw = ir_write;
    o.rdst = reg_dst; o.m2r = mem_to_reg; o.rw = reg_write; o.srcA = alu_src_a;
    o.srcB = alu_src_b; o.aluOp = alu_op; o.pcSrc = pc_source; o.ill = illegal_op;
    return o;
  endfunction

  function automatic obsT blank(input int st);
    obsT o = '0;
    o.st = st[3:0];
    return o;
  endfunction

  task automatic check(input string name, input obsT act, input obsT req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic add(input obsT o, input logic mr);
    stepT s;
    s.exp = o;
    s.mr  = mr;
    trace.push_back(s);
  endtask

  // Expected trace of one instruction: fs FETCH stalls, ms memory-phase stalls.
  // mem_ready is randomised wherever the FSM must ignore it.
  task automatic build(input logic [5:0] op, input int fs, input int ms);
    obsT  o;
    logic legal;
    trace.delete();
    for (int i = 0; i <= fs; i++) begin
      o = blank(0); o.mrd = 1'b1; o.srcB = 2'b01;
      o.irw = (i == fs); o.pcw = (i == fs);
      add(o, i == fs);
    end
    legal = op inside {RTYPE, JMP, BEQ, BNE, LW, SW, ADDI, ANDI, ORI, SLTI};
    o = blank(1); o.srcB = 2'b11; o.ill = !legal;
    add(o, 1'($urandom_range(0, 1)));
    case (op)
      RTYPE: begin
        o = blank(6); o.srcA = 1'b1; o.aluOp = 3'b110; add(o, 1'($urandom_range(0, 1)));
        o = blank(7); o.rw = 1'b1; o.rdst = 1'b1;     add(o, 1'($urandom_range(0, 1)));
      end
      LW, SW: begin
        o = blank(2); o.srcA = 1'b1; o.srcB = 2'b10;  add(o, 1'($urandom_range(0, 1)));
        for (int k = 0; k <= ms; k++) begin
          o = blank(op == LW ? 3 : 5); o.iord = 1'b1;
          if (op == LW) o.mrd = 1'b1; else o.mwr = 1'b1;
          add(o, k == ms);
        end
        if (op == LW) begin
          o = blank(4); o.rw = 1'b1; o.m2r = 1'b1;    add(o, 1'($urandom_range(0, 1)));
        end
      end
      BEQ, BNE: begin
        o = blank(8); o.srcA = 1'b1; o.aluOp = 3'b001; o.pcSrc = 2'b01;
        o.beq = (op == BEQ); o.bne = (op == BNE);
        add(o, 1'($urandom_range(0, 1)));
      end
      JMP: begin
        o = blank(9); o.pcw = 1'b1; o.pcSrc = 2'b10;  add(o, 1'($urandom_range(0, 1)));
      end
      ADDI, ANDI, ORI, SLTI: begin
        o = blank(10); o.srcA = 1'b1; o.srcB = 2'b10;
        o.aluOp = (op == ANDI) ? 3'b010 : (op == ORI) ? 3'b011 :
                  (op == SLTI) ? 3'b101 : 3'b000;
        add(o, 1'($urandom_range(0, 1)));
        o = blank(11); o.rw = 1'b1;                   add(o, 1'($urandom_range(0, 1)));
      end
      default: ;
    endcase
  endtask

  task automatic runTrace(input logic [5:0] op);
    foreach (trace[i]) begin
      @(negedge clk);
      if (i == 0) opcode = op;
      mem_ready = trace[i].mr;
      expQ.push_back(trace[i].exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    mem_ready = 1'b0;
    #3;
  endtask

  function automatic int countIrw();
    int n = 0;
    foreach (trace[i]) if (trace[i].exp.irw) n++;
    return n;
  endfunction

  // Per-cycle compare against the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        cmpExp = expQ.pop_front();
        cmpAct = observed();
        check("cycle", cmpAct, cmpExp);
        if (cmpAct.ill) illCnt++;
        if (cmpAct.rw)  rwCnt++;
        if (cmpAct.mwr) mwCnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    zeroObs   = '0;
    fetchIdle = blank(0); fetchIdle.mrd = 1'b1; fetchIdle.srcB = 2'b01;
    reset_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
    #2 check("resetOutputs", observed(), zeroObs);
    @(negedge clk);
    reset_n = 1'b1;

    build(RTYPE, 0, 0);
    checkInt("addLength", trace.size(), 4);
    checkInt("addExecState", int'(trace[2].exp.st), 6);
    runTrace(RTYPE);

    build(LW, 2, 3);
    checkInt("lwLength", trace.size(), 10);
    checkInt("lwIrPulses", countIrw(), 1);
    runTrace(LW);

    build(SW, 0, 0);  checkInt("swLength", trace.size(), 4);  runTrace(SW);
    build(SW, 1, 2);  runTrace(SW);
    build(BEQ, 0, 0); checkInt("beqLength", trace.size(), 3); runTrace(BEQ);
    build(BNE, 1, 0); checkInt("bneLength", trace.size(), 4); runTrace(BNE);
    build(ORI, 0, 0); checkInt("oriLength", trace.size(), 4); runTrace(ORI);
    build(SLTI, 0, 0); runTrace(SLTI);
    build(JMP, 0, 0); checkInt("jLength", trace.size(), 3);   runTrace(JMP);
    build(ADDI, 1, 0); runTrace(ADDI);
    build(ANDI, 0, 0); runTrace(ANDI);
    build(LW, 0, 0);  checkInt("lwFastLength", trace.size(), 5); runTrace(LW);
    drain();

    illCnt = 0; rwCnt = 0; mwCnt = 0;
    build(BAD, 0, 0);
    checkInt("badLength", trace.size(), 2);
    runTrace(BAD);
    drain();
    checkInt("illegalPulses", illCnt, 1);
    checkInt("illegalNoRegWrite", rwCnt, 0);
    checkInt("illegalNoMemWrite", mwCnt, 0);

    // Walk an LW into MEM_RD, then reset asynchronously mid-read
    opcode = LW; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 checkInt("inMemRd", int'(state), 3);
    #1 reset_n = 1'b0;
    #1 check("asyncReset", observed(), zeroObs);
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b0;
    #2 check("afterReset", observed(), fetchIdle);

    build(RTYPE, 1, 0);
    runTrace(RTYPE);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
